// File: rtl/exe_stage_mc.sv
// Execute stage: registers the decoded instruction, computes ALU results with a
// stalling radix-2 divider, drives the data SRAM request and forwards to decode.
module exe_stage_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            flush,
  input  logic                            ds2es_valid,
  output logic                            es_allowin,
  input  logic [31:0]                     ds_pc,
  input  logic [3:0]                      ds_op,
  input  logic [DATA_W-1:0]               ds_src1,
  input  logic [DATA_W-1:0]               ds_src2,
  input  logic [DATA_W-1:0]               ds_rkd,
  input  logic                            ds_mem_re,
  input  logic                            ds_mem_we,
  input  logic [1:0]                      ds_mem_size,
  input  logic                            ds_gr_we,
  input  logic [4:0]                      ds_dest,
  input  logic                            ms_allowin,
  output logic                            es2ms_valid,
  output logic [31:0]                     es2ms_pc,
  output logic [DATA_W-1:0]               es2ms_result,
  output logic                            es2ms_res_from_mem,
  output logic                            es2ms_gr_we,
  output logic [4:0]                      es2ms_dest,
  output logic [1:0]                      es2ms_mem_size,
  output logic [$clog2(DATA_W/8)-1:0]     es2ms_addr_lo,
  output logic                            es2ms_ale,
  output logic                            data_sram_en,
  output logic [DATA_W/8-1:0]             data_sram_we,
  output logic [ADDR_W-1:0]               data_sram_addr,
  output logic [DATA_W-1:0]               data_sram_wdata,
  output logic                            es_fwd_valid,
  output logic [4:0]                      es_fwd_dest,
  output logic [DATA_W-1:0]               es_fwd_data,
  output logic                            es_fwd_stall
);

  localparam int NB = DATA_W / 8;
  localparam int AL = $clog2(NB);
  localparam int SW = $clog2(DATA_W);
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL,
    OP_SRL, OP_SRA, OP_PASS2, OP_DIV, OP_DIVU, OP_MOD, OP_MODU, OP_RSV
  } op_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  logic              es_valid;
  logic [31:0]       pc_r;
  op_e               op_r;
  logic [DATA_W-1:0] src1_r, src2_r, rkd_r;
  logic              mem_re_r, mem_we_r, gr_we_r;
  logic [1:0]        size_r;
  logic [4:0]        dest_r;

  div_state_e        div_state;
  logic [CW-1:0]     div_cnt;
  logic [DATA_W-1:0] rem_q, quo_q, dsr_q;

  logic              is_div, is_signed, is_mod, es_ready_go, handoff;
  logic              sign1, sign2;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W:0]   trial, diff;
  logic              ge;
  logic [DATA_W-1:0] quo_fix, rem_fix, result;
  logic [AL-1:0]     addr_lo;
  logic              ale;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata;

  assign is_div      = op_r inside {OP_DIV, OP_DIVU, OP_MOD, OP_MODU};
  assign is_signed   = op_r inside {OP_DIV, OP_MOD};
  assign is_mod      = op_r inside {OP_MOD, OP_MODU};
  assign es_ready_go = ~is_div | (div_state == DIV_DONE);
  assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
  assign es2ms_valid = es_valid & es_ready_go & ~flush;
  assign handoff     = es2ms_valid & ms_allowin;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            es_valid <= 1'b0;
    else if (flush)         es_valid <= 1'b0;
    else if (es_allowin)    es_valid <= ds2es_valid;
  end

  // NOTE: payload registers take an explicit reset so a reset pipeline shows
  // deterministic values on every downstream port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r     <= '0;
      op_r     <= OP_ADD;
      src1_r   <= '0;
      src2_r   <= '0;
      rkd_r    <= '0;
      mem_re_r <= 1'b0;
      mem_we_r <= 1'b0;
      size_r   <= '0;
      gr_we_r  <= 1'b0;
      dest_r   <= '0;
    end else if (ds2es_valid && es_allowin) begin
      pc_r     <= ds_pc;
      op_r     <= op_e'(ds_op);
      src1_r   <= ds_src1;
      src2_r   <= ds_src2;
      rkd_r    <= ds_rkd;
      mem_re_r <= ds_mem_re;
      mem_we_r <= ds_mem_we;
      size_r   <= ds_mem_size;
      gr_we_r  <= ds_gr_we;
      dest_r   <= ds_dest;
    end
  end

  // Restoring division runs on magnitudes; signs are applied on the way out.
  assign sign1 = is_signed & src1_r[DATA_W-1];
  assign sign2 = is_signed & src2_r[DATA_W-1];
  assign mag1  = sign1 ? -src1_r : src1_r;
  assign mag2  = sign2 ? -src2_r : src2_r;
  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign diff  = trial - {1'b0, dsr_q};
  assign ge    = ~diff[DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
    end else begin
      case (div_state)
        DIV_IDLE: if (es_valid && is_div && !flush) begin
          div_state <= DIV_BUSY;
          div_cnt   <= '0;
          rem_q     <= '0;
          quo_q     <= mag1;
          dsr_q     <= mag2;
        end
        DIV_BUSY: if (flush) begin
          div_state <= DIV_IDLE;
          div_cnt   <= '0;
        end else begin
          rem_q   <= ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
          quo_q   <= {quo_q[DATA_W-2:0], ge};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CW'(DATA_W - 1)) div_state <= DIV_DONE;
        end
        DIV_DONE: if (flush || handoff) begin
          div_state <= DIV_IDLE;
          div_cnt   <= '0;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Zero divisor overrides the sign fix-up: quotient all-ones, remainder = dividend.
  always_comb begin
    quo_fix = (sign1 ^ sign2) ? -quo_q : quo_q;
    rem_fix = sign1 ? -rem_q : rem_q;
    if (src2_r == '0) begin
      quo_fix = '1;
      rem_fix = src1_r;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    result = src1_r + src2_r;
    case (op_r)
      OP_SUB:   result = src1_r - src2_r;
      OP_AND:   result = src1_r & src2_r;
      OP_OR:    result = src1_r | src2_r;
      OP_XOR:   result = src1_r ^ src2_r;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(src1_r) < $signed(src2_r)};
      OP_SLTU:  result = {{(DATA_W-1){1'b0}}, src1_r < src2_r};
      OP_SLL:   result = src1_r << src2_r[SW-1:0];
      OP_SRL:   result = src1_r >> src2_r[SW-1:0];
      OP_SRA:   result = $signed(src1_r) >>> src2_r[SW-1:0];
      OP_PASS2: result = src2_r;
      OP_DIV, OP_DIVU, OP_MOD, OP_MODU: result = is_mod ? rem_fix : quo_fix;
      default:  result = src1_r + src2_r;
    endcase
  end

  assign addr_lo = result[AL-1:0];

  always_comb begin
    ale = 1'b0;
    case (size_r)
      2'd1:    ale = addr_lo[0];
      2'd2:    ale = |addr_lo[1:0];
      2'd3:    ale = (DATA_W < 64) | (|addr_lo);
      default: ale = 1'b0;
    endcase
  end

  // Lane i carries byte (i mod access-size) of the store data.
  always_comb begin
    lane_mask = '0;
    wdata     = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i]    = (i < (1 << size_r));
      wdata[8*i +: 8] = rkd_r[8*(i % (1 << size_r)) +: 8];
    end
  end

  assign es2ms_ale       = ale & (mem_re_r | mem_we_r);
  assign data_sram_en    = handoff & (mem_re_r | mem_we_r) & ~ale;
  assign data_sram_we    = (data_sram_en & mem_we_r) ? (lane_mask << addr_lo) : '0;
  assign data_sram_addr  = result[ADDR_W-1:0];
  assign data_sram_wdata = wdata;

  assign es2ms_pc           = pc_r;
  assign es2ms_result       = result;
  assign es2ms_res_from_mem = mem_re_r;
  assign es2ms_gr_we        = gr_we_r;
  assign es2ms_dest         = dest_r;
  assign es2ms_mem_size     = size_r;
  assign es2ms_addr_lo      = addr_lo;

  assign es_fwd_valid = es_valid & gr_we_r & (dest_r != 5'd0);
  assign es_fwd_dest  = dest_r;
  assign es_fwd_data  = result;
  assign es_fwd_stall = es_valid & (mem_re_r | (is_div & (div_state != DIV_DONE)));

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc (DATA_W=32): ALU/divider vector table through a
// result scoreboard, plus hand sequences for stalls, stores, flush and reset.
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        resetn, flush, ds2es_valid, es_allowin;
  logic [31:0] ds_pc;
  logic [3:0]  ds_op;
  logic [31:0] ds_src1, ds_src2, ds_rkd;
  logic        ds_mem_re, ds_mem_we, ds_gr_we;
  logic [1:0]  ds_mem_size;
  logic [4:0]  ds_dest;
  logic        ms_allowin, es2ms_valid;
  logic [31:0] es2ms_pc, es2ms_result;
  logic        es2ms_res_from_mem, es2ms_gr_we;
  logic [4:0]  es2ms_dest;
  logic [1:0]  es2ms_mem_size, es2ms_addr_lo;
  logic        es2ms_ale, data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        es_fwd_valid, es_fwd_stall;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;

  exe_stage_mc #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ds2es_valid(ds2es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_op(ds_op), .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_rkd(ds_rkd),
    .ds_mem_re(ds_mem_re), .ds_mem_we(ds_mem_we), .ds_mem_size(ds_mem_size),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ms_allowin(ms_allowin),
    .es2ms_valid(es2ms_valid), .es2ms_pc(es2ms_pc), .es2ms_result(es2ms_result),
    .es2ms_res_from_mem(es2ms_res_from_mem), .es2ms_gr_we(es2ms_gr_we),
    .es2ms_dest(es2ms_dest), .es2ms_mem_size(es2ms_mem_size),
    .es2ms_addr_lo(es2ms_addr_lo), .es2ms_ale(es2ms_ale),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
    .es_fwd_data(es_fwd_data), .es_fwd_stall(es_fwd_stall)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                         SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9,
                         PASS2 = 4'd10, DIV = 4'd11, DIVU = 4'd12, MOD = 4'd13,
                         MODU = 4'd14, RSV = 4'd15;

  typedef struct { logic [31:0] result; logic ale; } exp_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

  exp_t sb[$];
  exp_t popped;
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every handoff the memory stage accepts must match the oldest entry.
  always @(negedge clk) begin
    if (resetn && es2ms_valid && ms_allowin) begin
      if (sb.size() == 0) check("unexpected handoff", 64'(es2ms_result), 64'hx);
      else begin
        popped = sb.pop_front();
        check("result", 64'(es2ms_result), 64'(popped.result));
        check("ale", 64'(es2ms_ale), 64'(popped.ale));
      end
    end
  end

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, b, exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Offers one instruction; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, b, rkd,
                      input logic re, we, input logic [1:0] size,
                      input logic [31:0] exp, input logic exp_ale, input bit push);
    int k;
    exp_t e;
    @(posedge clk); #1;
    ds2es_valid = 1'b1; ds_op = op; ds_src1 = a; ds_src2 = b; ds_rkd = rkd;
    ds_mem_re = re; ds_mem_we = we; ds_mem_size = size; ds_gr_we = 1'b1;
    ds_dest = 5'd3; ds_pc = ds_pc + 32'd4;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (es_allowin) break;
    end
    if (k == 200) check("allowin timeout", 64'(k), 64'd0);
    if (push) begin
      e.result = exp; e.ale = exp_ale;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ds2es_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) check("drain timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, seen;

    add_vec(ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000);
    add_vec(SUB,   32'd5,        32'd7,        32'hFFFFFFFE);
    add_vec(AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
    add_vec(OR,    32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0);
    add_vec(XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
    add_vec(SLT,   32'hFFFFFFFF, 32'h1,        32'h1);
    add_vec(SLTU,  32'hFFFFFFFF, 32'h1,        32'h0);
    add_vec(SLL,   32'h1,        32'h21,       32'h2);
    add_vec(SRL,   32'h80000000, 32'h1F,       32'h1);
    add_vec(SRA,   32'h80000000, 32'h4,        32'hF8000000);
    add_vec(PASS2, 32'hDEADBEEF, 32'h12345678, 32'h12345678);
    add_vec(RSV,   32'd3,        32'd4,        32'd7);
    add_vec(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    add_vec(MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    add_vec(DIVU,  32'd5,        32'd0,        32'hFFFFFFFF);
    add_vec(MODU,  32'd5,        32'd0,        32'd5);
    add_vec(MOD,   32'h80000000, 32'hFFFFFFFF, 32'h0);
    add_vec(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add_vec(DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    add_vec(MOD,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
    add_vec(DIVU,  32'd100,      32'd7,        32'd14);
    add_vec(MODU,  32'd100,      32'd7,        32'd2);
    add_vec(DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    add_vec(MOD,   32'd7,        32'hFFFFFFFE, 32'd1);
    add_vec(DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF);

    resetn = 1'b0; flush = 1'b0; ds2es_valid = 1'b0; ds_pc = 32'h0; ds_op = 4'd0;
    ds_src1 = '0; ds_src2 = '0; ds_rkd = '0; ds_mem_re = 1'b0; ds_mem_we = 1'b0;
    ds_mem_size = 2'd0; ds_gr_we = 1'b0; ds_dest = 5'd0; ms_allowin = 1'b1;
    #12;
    check("rst es_allowin", 64'(es_allowin), 64'd1);
    check("rst es2ms_valid", 64'(es2ms_valid), 64'd0);
    check("rst sram_en", 64'(data_sram_en), 64'd0);
    check("rst sram_we", 64'(data_sram_we), 64'd0);
    check("rst fwd_valid", 64'(es_fwd_valid), 64'd0);
    check("rst result", 64'(es2ms_result), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Non-divide op hands off in the cycle after acceptance, for one cycle.
    send(ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 2'd2, 32'h80000000, 1'b0, 1'b1);
    @(negedge clk);
    check("add valid", 64'(es2ms_valid), 64'd1);
    check("add fwd_valid", 64'(es_fwd_valid), 64'd1);
    @(negedge clk);
    check("add valid drop", 64'(es2ms_valid), 64'd0);
    drain();

    // Divide latency: valid at cycle T, handoff first visible at T+DATA_W+1.
    send(DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b0, 2'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("div allowin low", 64'(es_allowin), 64'd0);
        check("div fwd_stall", 64'(es_fwd_stall), 64'd1);
      end
      if (es2ms_valid) break;
    end
    check("div latency", 64'(k), 64'd33);
    drain();

    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, 32'h0, 1'b0, 1'b0, 2'd2, vecs[i].exp, 1'b0, 1'b1);
    drain();

    // Byte store held off by the memory stage for three cycles.
    ms_allowin = 1'b0;
    send(ADD, 32'h1000, 32'h3, 32'hAB, 1'b0, 1'b1, 2'd0, 32'h1003, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sb en held", 64'(data_sram_en), 64'd0);
    end
    @(posedge clk); #1 ms_allowin = 1'b1;
    @(negedge clk);
    check("sb en", 64'(data_sram_en), 64'd1);
    check("sb we", 64'(data_sram_we), 64'b1000);
    check("sb wdata", 64'(data_sram_wdata), 64'hABABABAB);
    check("sb addr", 64'(data_sram_addr), 64'h1003);
    @(negedge clk);
    check("sb en once", 64'(data_sram_en), 64'd0);
    drain();

    // Misaligned word store: handed off with ale, no SRAM access.
    send(ADD, 32'h1000, 32'h2, 32'h55, 1'b0, 1'b1, 2'd2, 32'h1002, 1'b1, 1'b1);
    @(negedge clk);
    check("sw ale en", 64'(data_sram_en), 64'd0);
    check("sw ale valid", 64'(es2ms_valid), 64'd1);
    check("sw ale flag", 64'(es2ms_ale), 64'd1);
    check("sw ale we", 64'(data_sram_we), 64'd0);
    drain();

    // Aligned halfword load.
    send(ADD, 32'h1000, 32'h2, 32'h0, 1'b1, 1'b0, 2'd1, 32'h1002, 1'b0, 1'b1);
    @(negedge clk);
    check("lh en", 64'(data_sram_en), 64'd1);
    check("lh we", 64'(data_sram_we), 64'd0);
    check("lh fwd_stall", 64'(es_fwd_stall), 64'd1);
    check("lh addr_lo", 64'(es2ms_addr_lo), 64'd2);
    drain();

    // Flush at cycle 10 of a divide, with decode offering an ADD in the same cycle.
    send(DIV, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd2, 32'd14, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1; ds2es_valid = 1'b1; ds_op = ADD; ds_src1 = 32'd1; ds_src2 = 32'd1;
    @(negedge clk);
    check("flush valid", 64'(es2ms_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; ds2es_valid = 1'b0;
    @(negedge clk);
    check("flush allowin", 64'(es_allowin), 64'd1);
    check("flush dropped", 64'(es_fwd_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (es2ms_valid) seen++;
    end
    check("flush no handoff", 64'(seen), 64'd0);
    send(ADD, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 2'd2, 32'd5, 1'b0, 1'b1);
    drain();

    // Asynchronous reset in the middle of a division.
    send(DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd2, 32'd14, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("areset allowin", 64'(es_allowin), 64'd1);
    check("areset stall", 64'(es_fwd_stall), 64'd0);
    check("areset valid", 64'(es2ms_valid), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    send(MODU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd2, 32'd2, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
